// File: rtl/bcd_tick_counter_if.sv
// bcd_tick_counter_if: control and packed BCD display bus between a controller and the tick counter
interface bcd_tick_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  clr;
    logic                  dir;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  lap;
    logic [4*DIGITS-1:0]   count;
    logic                  tick;
    logic                  wrap;
    logic                  lap_active;

    modport master (
        output en, clr, dir, load, load_val, lap,
        input  count, tick, wrap, lap_active
    );

    modport slave (
        input  en, clr, dir, load, load_val, lap,
        output count, tick, wrap, lap_active
    );
endinterface

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled N-digit up/down BCD counter; lap hold is built when BCD_TICK_COUNTER_LAP_EN is defined
module bcd_tick_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_tick_counter_if.slave     bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int W   = 4 * DIGITS;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] r_pre;
    logic [W-1:0]  r_dig;
    logic [W-1:0]  r_count;
    logic          r_tick;
    logic          r_wrap;
    logic          r_lap;

    logic [W-1:0]  w_step;
    logic          w_carry;
    logic [W-1:0]  w_ld;
    logic          w_adv;
    logic [W-1:0]  w_dig_next;
    logic [PW-1:0] w_pre_next;
    logic          w_lap_next;

    // one decimal step of the live digits; carry/borrow ripples from digit 0 and falls out as wrap
    always_comb begin
        w_step  = r_dig;
        w_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_step[4*k +: 4] = !w_carry ? r_dig[4*k +: 4] :
                               bus.dir  ? (r_dig[4*k +: 4] == 4'd0 ? 4'd9 : r_dig[4*k +: 4] - 4'd1) :
                                          (r_dig[4*k +: 4] == 4'd9 ? 4'd0 : r_dig[4*k +: 4] + 4'd1);
            w_carry = w_carry && (r_dig[4*k +: 4] == (bus.dir ? 4'd0 : 4'd9));
        end
    end

    // load value with out-of-range nibbles clamped to 9 so digit state stays valid BCD
    always_comb begin
        w_ld = '0;
        for (int k = 0; k < DIGITS; k++)
            w_ld[4*k +: 4] = bus.load_val[4*k +: 4] > 4'd9 ? 4'd9 : bus.load_val[4*k +: 4];
    end

    // next-state selection in priority order clr, load, advance
    always_comb begin
        w_adv      = bus.en && r_pre == PMAX && !bus.clr && !bus.load;
        w_dig_next = bus.clr ? '0 : bus.load ? w_ld : w_adv ? w_step : r_dig;
        w_pre_next = (bus.clr || bus.load) ? '0 : !bus.en ? r_pre : r_pre == PMAX ? '0 : r_pre + 1'b1;
`ifdef BCD_TICK_COUNTER_LAP_EN
        w_lap_next = bus.clr ? 1'b0 : r_lap ^ bus.lap;
`else
        w_lap_next = 1'b0;
`endif
    end

`ifndef BCD_TICK_COUNTER_LAP_EN
    logic w_unused;
    assign w_unused = bus.lap;
`endif

    // registered state; while the hold is (or becomes) engaged the displayed value keeps its last live value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_dig   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_lap   <= 1'b0;
        end else begin
            r_pre   <= w_pre_next;
            r_dig   <= w_dig_next;
            r_count <= w_lap_next ? r_count : w_dig_next;
            r_tick  <= w_adv;
            r_wrap  <= w_adv && w_carry;
            r_lap   <= w_lap_next;
        end
    end

    assign bus.count      = r_count;
    assign bus.tick       = r_tick;
    assign bus.wrap       = r_wrap;
    assign bus.lap_active = r_lap;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: directed checks of the 2-digit, DIV=10 BCD tick counter
module tb_bcd_tick_counter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bcd_tick_counter_if #(.DIGITS(2)) bus ();

    bcd_tick_counter #(.CLK_HZ(20), .TICK_HZ(2), .DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", bus.count); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", bus.tick); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
        checks++; if (bus.lap_active !== 1'b0) begin errors++; $display("FAIL reset_lap got %b want 0", bus.lap_active); end
        rst    = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic test_count_up();
        int v = 0;
        int nw = 0;
        for (int c = 1; c <= 1000; c++) begin
            step();
            if (c % 10 == 0) v = (v + 1) % 100;
            checks++; if (bus.tick !== (c % 10 == 0)) begin errors++; $display("FAIL up_tick c=%0d got %b want %b", c, bus.tick, c % 10 == 0); end
            checks++; if (bus.count !== bcd(v)) begin errors++; $display("FAIL up_count c=%0d got %h want %h", c, bus.count, bcd(v)); end
            checks++; if (bus.wrap !== (c == 1000)) begin errors++; $display("FAIL up_wrap c=%0d got %b want %b", c, bus.wrap, c == 1000); end
            if (bus.wrap === 1'b1) nw++;
        end
        checks++; if (nw != 1) begin errors++; $display("FAIL up_wrap_count got %0d want 1", nw); end
    endtask

    task automatic test_count_down();
        int v = 5;
        logic t;
        bus.load     = 1'b1;
        bus.load_val = 8'h05;
        bus.dir      = 1'b1;
        step();
        bus.load = 1'b0;
        checks++; if (bus.count !== 8'h05) begin errors++; $display("FAIL down_load got %h want 05", bus.count); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL down_load_tick got %b want 0", bus.tick); end
        for (int c = 1; c <= 70; c++) begin
            step();
            t = (c % 10 == 0);
            if (t) v = (v + 99) % 100;
            checks++; if (bus.tick !== t) begin errors++; $display("FAIL down_tick c=%0d got %b want %b", c, bus.tick, t); end
            checks++; if (bus.count !== bcd(v)) begin errors++; $display("FAIL down_count c=%0d got %h want %h", c, bus.count, bcd(v)); end
            checks++; if (bus.wrap !== (t && v == 99)) begin errors++; $display("FAIL down_wrap c=%0d got %b want %b", c, bus.wrap, t && v == 99); end
        end
    endtask

    task automatic test_load_clr();
        bus.dir      = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 8'hA3;
        step();
        bus.load = 1'b0;
        checks++; if (bus.count !== 8'h93) begin errors++; $display("FAIL clamp_count got %h want 93", bus.count); end
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL pre_adv_tick c=%0d got %b want 0", c, bus.tick); end
        end
        bus.load     = 1'b1;
        bus.clr      = 1'b1;
        bus.load_val = 8'h55;
        step();
        bus.load = 1'b0;
        bus.clr  = 1'b0;
        checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL clr_load_count got %h want 00", bus.count); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL clr_load_tick got %b want 0", bus.tick); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL clr_load_wrap got %b want 0", bus.wrap); end
        for (int c = 1; c <= 10; c++) begin
            step();
            checks++; if (bus.tick !== (c == 10)) begin errors++; $display("FAIL after_clr_tick c=%0d got %b want %b", c, bus.tick, c == 10); end
        end
        checks++; if (bus.count !== 8'h01) begin errors++; $display("FAIL after_clr_count got %h want 01", bus.count); end
    endtask

    task automatic test_en_pause();
        pulse_clr();
        repeat (7) step();
        bus.en = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            step();
            checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL pause_tick c=%0d got %b want 0", c, bus.tick); end
        end
        checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL pause_count got %h want 00", bus.count); end
        bus.en = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++; if (bus.tick !== (c == 3)) begin errors++; $display("FAIL resume_tick c=%0d got %b want %b", c, bus.tick, c == 3); end
        end
        checks++; if (bus.count !== 8'h01) begin errors++; $display("FAIL resume_count got %h want 01", bus.count); end
    endtask

`ifdef BCD_TICK_COUNTER_LAP_EN
    task automatic test_lap();
        pulse_clr();
        repeat (120) step();
        checks++; if (bus.count !== 8'h12) begin errors++; $display("FAIL lap_pre_count got %h want 12", bus.count); end
        bus.lap = 1'b1;
        step();
        bus.lap = 1'b0;
        checks++; if (bus.lap_active !== 1'b1) begin errors++; $display("FAIL lap_engage got %b want 1", bus.lap_active); end
        repeat (300) step();
        checks++; if (bus.count !== 8'h12) begin errors++; $display("FAIL lap_hold_count got %h want 12", bus.count); end
        checks++; if (bus.lap_active !== 1'b1) begin errors++; $display("FAIL lap_hold_active got %b want 1", bus.lap_active); end
        bus.lap = 1'b1;
        step();
        bus.lap = 1'b0;
        checks++; if (bus.count !== 8'h42) begin errors++; $display("FAIL lap_release_count got %h want 42", bus.count); end
        checks++; if (bus.lap_active !== 1'b0) begin errors++; $display("FAIL lap_release_active got %b want 0", bus.lap_active); end
    endtask
`else
    task automatic test_lap();
        pulse_clr();
        bus.lap = 1'b1;
        step();
        bus.lap = 1'b0;
        checks++; if (bus.lap_active !== 1'b0) begin errors++; $display("FAIL lap_ignored_active got %b want 0", bus.lap_active); end
        repeat (9) step();
        checks++; if (bus.count !== 8'h01) begin errors++; $display("FAIL lap_ignored_count got %h want 01", bus.count); end
    endtask
`endif

    task automatic test_rst_mid();
        pulse_clr();
        repeat (376) step();
        checks++; if (bus.count !== 8'h37) begin errors++; $display("FAIL rst_pre_count got %h want 37", bus.count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL rst_mid_count got %h want 00", bus.count); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL rst_mid_tick got %b want 0", bus.tick); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL rst_mid_wrap got %b want 0", bus.wrap); end
        checks++; if (bus.lap_active !== 1'b0) begin errors++; $display("FAIL rst_mid_lap got %b want 0", bus.lap_active); end
        for (int c = 1; c <= 10; c++) begin
            step();
            checks++; if (bus.tick !== (c == 10)) begin errors++; $display("FAIL rst_restart_tick c=%0d got %b want %b", c, bus.tick, c == 10); end
        end
        checks++; if (bus.count !== 8'h01) begin errors++; $display("FAIL rst_restart_count got %h want 01", bus.count); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.clr      = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;
        bus.lap      = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clr();
        test_en_pause();
        test_lap();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised multi-digit BCD tick counter: a clock prescaler generates a tick every CLK_HZ/TICK_HZ cycles, and an N-digit decimal counter advances on each tick, up or down, with load, clear and wrap indication. It is the timebase/counting core for stopwatch, timer and display demos. It feeds the seven-segment multiplexer directly through a packed BCD bus. An optional lap-hold function freezes the displayed value while counting continues.

## Interface
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 10, count rate. CLK_HZ/TICK_HZ must be an integer ≥ 2.
- DIGITS, 4, number of BCD digits, 1..8.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable; prescaler and digits hold when low.
- clr  in  1  synchronous clear of prescaler, digits and lap hold.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  load digits from load_val.
- load_val  in  4*DIGITS  packed BCD load value, digit 0 in [3:0].
- lap  in  1  lap-hold toggle, single-cycle pulse (LAP_EN builds only).
- count  out  4*DIGITS  packed BCD output value.
- tick  out  1  one-cycle pulse when the digits advance.
- wrap  out  1  one-cycle pulse when the counter wraps end to end.
- lap_active  out  1  lap hold engaged.

## Operation
- DIV = CLK_HZ/TICK_HZ. The prescaler is $clog2(DIV) bits wide and counts 0..DIV-1 while en=1. It holds its value while en=0.
- Advance event: the prescaler equals DIV-1, en=1, and neither clr nor load is asserted. On this event the prescaler returns to 0.
- Up count: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. All-9s becomes all-0s and asserts wrap.
- Down count: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All-0s becomes all-9s and asserts wrap.
- dir is sampled only on the advance event. Changing dir never alters the digits or the prescaler by itself.
- Priority, highest first: rst, clr, load, advance.
- clr: digits = 0, prescaler = 0, lap hold released. No tick and no wrap.
- load: digits = load_val, prescaler = 0. Any load_val nibble greater than 9 is loaded as 9. No tick and no wrap. load is honoured when en=0.
- Digit state is always valid BCD (0..9 per nibble).
- count shows the live digits, except while lap hold is engaged (see Configuration).

## Timing
- Reset values: count = 0, tick = 0, wrap = 0, lap_active = 0, prescaler = 0, digits = 0.
- All outputs are registered.
- tick, wrap and the new count value appear together in the cycle after the advance event.
- With en held high continuously, tick recurs exactly every DIV cycles. The first tick after reset occurs DIV cycles after rst is released.
- Dropping en mid-period freezes the prescaler. Raising en again resumes from the same prescaler value, so the phase is preserved.
- load or clr in the same cycle as a pending advance: the advance is discarded, and the next tick follows DIV cycles later.
- rst mid-period: all state returns to reset values on the next edge.
- wrap never asserts without tick in the same cycle.

## Configuration
- Macro: BCD_TICK_COUNTER_LAP_EN.
- Defined:
  - A lap pulse toggles the hold.
  - On engage, count captures the current live digits and stays frozen while the live digits keep counting.
  - On release, count follows the live digits again from the next cycle.
  - lap_active reflects the hold state, registered, one cycle after the lap pulse.
  - clr and rst release the hold.
  - load updates the live digits only; a frozen count is not changed.
- Not defined:
  - No hold logic is built.
  - lap is ignored.
  - lap_active is tied to 0.
  - count always shows the live digits.

## Test plan
All scenarios use CLK_HZ=20, TICK_HZ=2 (DIV=10), DIGITS=2.
- Reset release, en=1, dir=0 for 1000 cycles: tick every 10 cycles; count steps 00→01→…→99→00; wrap asserts exactly once, in the same cycle as 99→00.
- load_val=0x05, dir=1, en=1: count goes 05→04→…→00→99; wrap is pulsed on 00→99.
- load_val=0xA3: count = 0x93. Then load, clr and an advance event in the same cycle: count = 00, no tick, and the next tick arrives 10 cycles later.
- en=1 for 7 cycles, en=0 for 50 cycles, then en=1: the first tick arrives 3 cycles after en returns high.
- LAP_EN build, lap pulsed at count=12, counter runs 30 more ticks: count holds at 12 and lap_active=1. A second lap pulse makes count show the live value of 42.
- rst asserted mid-count at count=37 with the prescaler at 6: next cycle count = 00, the prescaler restarts from 0, and tick, wrap and lap_active are 0.
